// File: rtl/sramfb_pkg.sv
// ---------------------------------------------------------------------------
// sramfb_pkg
// Definitions shared by the SRAM framebuffer test-pattern generator and the
// read-side pattern checker.
//   - chk_state_e  : checker lock state (SEEK / CONFIRM / LOCKED)
//   - SAMPLE_PHASE : memory-cycle phase on which read data is valid. The
//                    generator uses the same constant, so the write phase and
//                    the check phase stay aligned.
//   - seq_next()   : next word of the incrementing test pattern.
// ---------------------------------------------------------------------------
package sramfb_pkg;

   typedef enum logic [1:0] {
      SEEK    = 2'd0,
      CONFIRM = 2'd1,
      LOCKED  = 2'd2
   } chk_state_e;

   localparam logic [2:0] SAMPLE_PHASE = 3'b101;

   // The pattern wraps modulo 2^16: 16'hFFFF is followed by 16'h0000.
   function automatic logic [15:0] seq_next(input logic [15:0] word);
      return word + 16'd1;
   endfunction

endpackage

// File: rtl/sram_pattern_checker.sv
// ---------------------------------------------------------------------------
// sram_pattern_checker
// Checks 16-bit SRAM read words against the incrementing test pattern. One
// word is sampled per 8-phase memory cycle. The checker locks onto the
// stream after two sequential words and counts mismatches while locked. It
// captures the first failing word and re-seeks after LOSS_THRESHOLD
// consecutive misses.
//
// Parameters
//   SAMPLE_PHASE   : clkPhase value on which data_in is sampled
//   LOSS_THRESHOLD : consecutive misses in LOCKED that force a re-seek (1..15)
//   ERRCNT_W       : width of error_count
// Ports
//   clk, reset_n         : clock, asynchronous active-low reset
//   clkPhase             : shared memory-cycle phase counter
//   enable               : checking enabled (low freezes everything)
//   clear                : synchronous restart to SEEK with counters cleared
//   data_in              : read data from the SRAM interface
//   locked               : checker is locked onto the stream
//   err_pulse            : one-clk pulse per counted mismatch
//   error_count          : saturating mismatch count
//   word_count           : words checked while locked (wraps)
//   resync_count         : saturating count of lock losses
//   first_err_valid/_data/_expected : first-mismatch capture
// ---------------------------------------------------------------------------
module sram_pattern_checker
   import sramfb_pkg::*;
#(
   parameter logic [2:0] SAMPLE_PHASE   = sramfb_pkg::SAMPLE_PHASE,
   parameter int         LOSS_THRESHOLD = 4,
   parameter int         ERRCNT_W       = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [2:0]          clkPhase,
   input  logic                enable,
   input  logic                clear,
   input  logic [15:0]         data_in,
   output logic                locked,
   output logic                err_pulse,
   output logic [ERRCNT_W-1:0] error_count,
   output logic [31:0]         word_count,
   output logic [7:0]          resync_count,
   output logic                first_err_valid,
   output logic [15:0]         first_err_data,
   output logic [15:0]         first_err_expected
);

   localparam logic [3:0] LOSS_TH = 4'(LOSS_THRESHOLD);

   chk_state_e            state_q,           state_d;
   logic [15:0]           expected_q,        expected_d;
   logic [3:0]            miss_run_q,        miss_run_d;
   logic                  err_pulse_q,       err_pulse_d;
   logic [ERRCNT_W-1:0]   error_count_q,     error_count_d;
   logic [31:0]           word_count_q,      word_count_d;
   logic [7:0]            resync_count_q,    resync_count_d;
   logic                  first_err_valid_q, first_err_valid_d;
   logic [15:0]           first_err_data_q,  first_err_data_d;
   logic [15:0]           first_err_exp_q,   first_err_exp_d;

   logic                  sample_s;
   logic                  match_s;
   logic [3:0]            miss_run_inc_s;

   // A sample is taken once per memory cycle, only while checking is enabled.
   assign sample_s       = (clkPhase == SAMPLE_PHASE) && enable && !clear;
   assign match_s        = (data_in == expected_q);
   assign miss_run_inc_s = miss_run_q + 4'd1;

   // State and counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q           <= SEEK;
         expected_q        <= 16'h0000;
         miss_run_q        <= 4'd0;
         err_pulse_q       <= 1'b0;
         error_count_q     <= '0;
         word_count_q      <= 32'd0;
         resync_count_q    <= 8'd0;
         first_err_valid_q <= 1'b0;
         first_err_data_q  <= 16'h0000;
         first_err_exp_q   <= 16'h0000;
      end else begin
         state_q           <= state_d;
         expected_q        <= expected_d;
         miss_run_q        <= miss_run_d;
         err_pulse_q       <= err_pulse_d;
         error_count_q     <= error_count_d;
         word_count_q      <= word_count_d;
         resync_count_q    <= resync_count_d;
         first_err_valid_q <= first_err_valid_d;
         first_err_data_q  <= first_err_data_d;
         first_err_exp_q   <= first_err_exp_d;
      end
   end

   // Next-state logic: lock tracking, mismatch accounting and first-error capture.
   always_comb begin
      state_d           = state_q;
      expected_d        = expected_q;
      miss_run_d        = miss_run_q;
      err_pulse_d       = 1'b0;
      error_count_d     = error_count_q;
      word_count_d      = word_count_q;
      resync_count_d    = resync_count_q;
      first_err_valid_d = first_err_valid_q;
      first_err_data_d  = first_err_data_q;
      first_err_exp_d   = first_err_exp_q;

      if (clear) begin
         // Clear wins over a coincident sample; that sample is dropped.
         state_d           = SEEK;
         miss_run_d        = 4'd0;
         error_count_d     = '0;
         word_count_d      = 32'd0;
         resync_count_d    = 8'd0;
         first_err_valid_d = 1'b0;
         first_err_data_d  = 16'h0000;
         first_err_exp_d   = 16'h0000;
      end else if (sample_s) begin
         case (state_q)
            SEEK: begin
               expected_d = seq_next(data_in);
               state_d    = CONFIRM;
            end
            CONFIRM: begin
               // Before lock a miss only re-seeds; nothing is counted.
               if (match_s) begin
                  expected_d = seq_next(expected_q);
                  state_d    = LOCKED;
               end else begin
                  expected_d = seq_next(data_in);
               end
            end
            LOCKED: begin
               // Expected keeps advancing on a miss, so an isolated bad
               // word does not desynchronise the checker.
               word_count_d = word_count_q + 32'd1;
               expected_d   = seq_next(expected_q);
               if (match_s) begin
                  miss_run_d = 4'd0;
               end else begin
                  err_pulse_d = 1'b1;
                  if (error_count_q != {ERRCNT_W{1'b1}}) begin
                     error_count_d = error_count_q + ERRCNT_W'(1);
                  end else begin
                     error_count_d = error_count_q;
                  end
                  // Captured once per reset/clear, surviving resyncs.
                  if (!first_err_valid_q) begin
                     first_err_valid_d = 1'b1;
                     first_err_data_d  = data_in;
                     first_err_exp_d   = expected_q;
                  end else begin
                     first_err_valid_d = first_err_valid_q;
                  end
                  if (miss_run_inc_s == LOSS_TH) begin
                     state_d    = SEEK;
                     miss_run_d = 4'd0;
                     if (resync_count_q != 8'hFF) begin
                        resync_count_d = resync_count_q + 8'd1;
                     end else begin
                        resync_count_d = resync_count_q;
                     end
                  end else begin
                     miss_run_d = miss_run_inc_s;
                  end
               end
            end
            default: begin
               state_d    = SEEK;
               miss_run_d = 4'd0;
            end
         endcase
      end else begin
         // No sample this clk: hold everything, err_pulse returns low.
         err_pulse_d = 1'b0;
      end
   end

   assign locked             = (state_q == LOCKED);
   assign err_pulse          = err_pulse_q;
   assign error_count        = error_count_q;
   assign word_count         = word_count_q;
   assign resync_count       = resync_count_q;
   assign first_err_valid    = first_err_valid_q;
   assign first_err_data     = first_err_data_q;
   assign first_err_expected = first_err_exp_q;

endmodule

// File: tb/tb_sram_pattern_checker.sv
// ---------------------------------------------------------------------------
// tb_sram_pattern_checker
// Drives memory cycles (8 clk each, data on phase 5) into the checker and
// compares every output against a behavioural model of the checker rules.
// ---------------------------------------------------------------------------
module tb_sram_pattern_checker;

   logic        clk;
   logic        reset_n;
   logic [2:0]  clkPhase;
   logic        enable;
   logic        clear;
   logic [15:0] data_in;
   logic        locked;
   logic        err_pulse;
   logic [15:0] error_count;
   logic [31:0] word_count;
   logic [7:0]  resync_count;
   logic        first_err_valid;
   logic [15:0] first_err_data;
   logic [15:0] first_err_expected;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state (0 = seeking, 1 = confirming, 2 = locked)
   int          m_state;
   int          m_exp;
   int          m_miss;
   int          m_err;
   logic [31:0] m_words;
   int          m_resync;
   logic        m_fev;
   int          m_fed;
   int          m_fee;
   logic        m_pulse;

   sram_pattern_checker #(
      .LOSS_THRESHOLD(4),
      .ERRCNT_W(16)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .clkPhase(clkPhase),
      .enable(enable),
      .clear(clear),
      .data_in(data_in),
      .locked(locked),
      .err_pulse(err_pulse),
      .error_count(error_count),
      .word_count(word_count),
      .resync_count(resync_count),
      .first_err_valid(first_err_valid),
      .first_err_data(first_err_data),
      .first_err_expected(first_err_expected)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_exp = 0; m_miss = 0; m_err = 0; m_words = 32'd0;
      m_resync = 0; m_fev = 1'b0; m_fed = 0; m_fee = 0; m_pulse = 1'b0;
   endtask

   task automatic model_sample(input int d, input logic en, input logic clr);
      m_pulse = 1'b0;
      if (clr) begin
         m_state = 0; m_miss = 0; m_err = 0; m_words = 32'd0; m_resync = 0;
         m_fev = 1'b0; m_fed = 0; m_fee = 0;
      end else if (en) begin
         if (m_state == 0) begin
            m_exp = (d + 1) % 65536;
            m_state = 1;
         end else if (m_state == 1) begin
            if (d == m_exp) begin
               m_exp = (m_exp + 1) % 65536;
               m_state = 2;
            end else begin
               m_exp = (d + 1) % 65536;
            end
         end else begin
            m_words = m_words + 32'd1;
            if (d == m_exp) begin
               m_miss = 0;
            end else begin
               m_pulse = 1'b1;
               if (m_err < 65535) m_err++;
               if (!m_fev) begin
                  m_fev = 1'b1; m_fed = d; m_fee = m_exp;
               end
               m_miss++;
               if (m_miss == 4) begin
                  m_state = 0; m_miss = 0;
                  if (m_resync < 255) m_resync++;
               end
            end
            m_exp = (m_exp + 1) % 65536;
         end
      end
   endtask

   task automatic check_all();
      check_val("locked",      32'(locked),             32'(m_state == 2));
      check_val("err_pulse",   32'(err_pulse),          32'(m_pulse));
      check_val("error_count", 32'(error_count),        32'(m_err));
      check_val("word_count",  word_count,              m_words);
      check_val("resync",      32'(resync_count),       32'(m_resync));
      check_val("ferr_valid",  32'(first_err_valid),    32'(m_fev));
      check_val("ferr_data",   32'(first_err_data),     32'(m_fed));
      check_val("ferr_exp",    32'(first_err_expected), 32'(m_fee));
   endtask

   // One memory cycle: word d presented on phase 5, junk on the other phases.
   task automatic mem_cycle(input logic [15:0] d, input logic en, input logic clr);
      for (int ph = 0; ph < 8; ph++) begin
         @(negedge clk);
         clkPhase = 3'(ph);
         clear    = (ph == 5) ? clr : 1'b0;
         data_in  = (ph == 5) ? d : 16'($urandom);
         enable   = (ph == 5) ? en : 1'($urandom);
         @(posedge clk);
         #1;
         if (ph == 5) begin
            model_sample(int'(d), en, clr);
            check_all();
         end else if (ph == 6) begin
            m_pulse = 1'b0;
            check_all();
         end
      end
   endtask

   task automatic stream(input logic [15:0] start, input int n);
      logic [15:0] w;
      w = start;
      for (int i = 0; i < n; i++) begin
         mem_cycle(w, 1'b1, 1'b0);
         w = w + 16'd1;
      end
   endtask

   initial begin
      logic [15:0] cur;
      int          bad_left;
      int          r;

      reset_n  = 1'b0;
      clkPhase = 3'd0;
      enable   = 1'b0;
      clear    = 1'b0;
      data_in  = 16'h0000;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      reset_n = 1'b1;

      // Clean stream 0x0000..0x0010: lock on 2nd sample, 15 words checked
      mem_cycle(16'h0000, 1'b1, 1'b0);
      check_val("no_lock_1st", 32'(locked), 32'd0);
      mem_cycle(16'h0001, 1'b1, 1'b0);
      check_val("lock_2nd", 32'(locked), 32'd1);
      stream(16'h0002, 15);
      check_val("clean_words", word_count, 32'd15);
      check_val("clean_errs", 32'(error_count), 32'd0);

      // Single corrupted word while locked
      mem_cycle(16'h0000, 1'b1, 1'b1);
      stream(16'h0000, 8);
      mem_cycle(16'h0808, 1'b1, 1'b0);
      mem_cycle(16'h0009, 1'b1, 1'b0);
      check_val("single_errs", 32'(error_count), 32'd1);
      check_val("single_fdata", 32'(first_err_data), 32'h0808);
      check_val("single_fexp", 32'(first_err_expected), 32'h0008);
      check_val("single_lock", 32'(locked), 32'd1);

      // Wrap across 0xFFFF
      mem_cycle(16'h0000, 1'b1, 1'b1);
      stream(16'hFFFE, 4);
      check_val("wrap_lock", 32'(locked), 32'd1);
      check_val("wrap_errs", 32'(error_count), 32'd0);

      // Four bad words force a re-seek, then relock at 0x1234
      stream(16'h0002, 2);
      mem_cycle(16'hAAAA, 1'b1, 1'b0);
      mem_cycle(16'h5555, 1'b1, 1'b0);
      mem_cycle(16'hAAAA, 1'b1, 1'b0);
      check_val("loss_still_lock", 32'(locked), 32'd1);
      mem_cycle(16'h5555, 1'b1, 1'b0);
      check_val("loss_unlock", 32'(locked), 32'd0);
      check_val("loss_errs", 32'(error_count), 32'd4);
      check_val("loss_resync", 32'(resync_count), 32'd1);
      stream(16'h1234, 2);
      check_val("relock", 32'(locked), 32'd1);
      check_val("relock_fdata", 32'(first_err_data), 32'hAAAA);
      check_val("relock_fexp", 32'(first_err_expected), 32'h0004);

      // enable low: nothing moves even with a wrong word
      mem_cycle(16'hBEEF, 1'b0, 1'b0);
      mem_cycle(16'hBEEF, 1'b0, 1'b0);
      stream(16'h1236, 2);

      // clear coincident with a mismatching sample
      mem_cycle(16'hDEAD, 1'b1, 1'b1);
      check_val("clr_lock", 32'(locked), 32'd0);
      check_val("clr_pulse", 32'(err_pulse), 32'd0);
      check_val("clr_errs", 32'(error_count), 32'd0);

      // Asynchronous reset mid-stream
      stream(16'h4000, 5);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      reset_n = 1'b1;
      stream(16'h7000, 2);
      check_val("post_rst_lock", 32'(locked), 32'd1);

      // Randomized stream: bad words, bursts, jumps, enable gaps, clears
      cur = 16'($urandom);
      bad_left = 0;
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 99));
         if (bad_left > 0) begin
            mem_cycle(cur ^ 16'h0100, 1'b1, 1'b0);
            bad_left--;
            cur = cur + 16'd1;
         end else if (r < 3) begin
            mem_cycle(16'($urandom), 1'b1, 1'b1);
         end else if (r < 10) begin
            mem_cycle(16'($urandom), 1'b0, 1'b0);
         end else if (r < 14) begin
            bad_left = int'($urandom_range(3, 5));
         end else if (r < 18) begin
            cur = 16'($urandom);
            mem_cycle(cur, 1'b1, 1'b0);
            cur = cur + 16'd1;
         end else if (r < 28) begin
            mem_cycle(cur ^ 16'(1 << $urandom_range(0, 15)), 1'b1, 1'b0);
            cur = cur + 16'd1;
         end else begin
            mem_cycle(cur, 1'b1, 1'b0);
            cur = cur + 16'd1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
